// File: rtl/ws2812_tx_driver_pkg.sv
// Shared types and nominal timing for the WS2812 transmit driver.
package ws2812_tx_driver_pkg;

    // Nominal timing at 50 MHz.
    localparam int unsigned T0H_CYC_DEF  = 20;
    localparam int unsigned T1H_CYC_DEF  = 40;
    localparam int unsigned TBIT_CYC_DEF = 63;
    localparam int unsigned TRET_CYC_DEF = 2600;

    localparam int unsigned WORD_W = 24;
    localparam int unsigned IDX_W  = 5;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HIGH = 3'd1,
        ST_LOW  = 3'd2,
        ST_GAP  = 3'd3,
        ST_RET  = 3'd4
    } tx_state_e;

    typedef struct packed {
        logic              last;
        logic [WORD_W-1:0] data;
    } pixel_t;

endpackage

// File: rtl/ws2812_tx_driver_bit_encoder.sv
// Pulse-width encoder: owns the cycle counter and the registered serial line.
// start begins a bit period (high phase first); hold begins a low-only wait.
module ws2812_tx_driver_bit_encoder
    import ws2812_tx_driver_pkg::*;
#(
    parameter int unsigned T0H_CYC  = T0H_CYC_DEF,
    parameter int unsigned T1H_CYC  = T1H_CYC_DEF,
    parameter int unsigned TBIT_CYC = TBIT_CYC_DEF,
    parameter int unsigned TRET_CYC = TRET_CYC_DEF,
    localparam int unsigned CNT_W   = $clog2(TRET_CYC + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             bit_val,
    input  logic             hold,
    output logic             serial,
    output logic [CNT_W-1:0] cnt,
    output logic             high_done_c,
    output logic             bit_done_c
);

    logic             bit_q;
    logic [CNT_W-1:0] t_high_c;

    // Last high cycle depends on the bit being sent; bit period ends at TBIT-1.
    assign t_high_c    = bit_q ? CNT_W'(T1H_CYC - 1) : CNT_W'(T0H_CYC - 1);
    assign high_done_c = serial && (cnt == t_high_c);
    assign bit_done_c  = (cnt == CNT_W'(TBIT_CYC - 1));

    // Counter and line: restart on start/hold, otherwise count and drop after the high time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            serial <= 1'b0;
            bit_q  <= 1'b0;
        end else if (start) begin
            cnt    <= '0;
            serial <= 1'b1;
            bit_q  <= bit_val;
        end else if (hold) begin
            cnt    <= '0;
            serial <= 1'b0;
        end else begin
            cnt <= cnt + CNT_W'(1);
            if (high_done_c) begin
                serial <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ws2812_tx_driver.sv
// WS2812 chain driver: valid/ready pixel intake, MSB-first pulse-width
// serialisation and end-of-frame latch low period.
// Optional feature macro: WS2812_TX_PREFETCH_EN adds a one-word holding
// register so consecutive pixels stream without a gap.
module ws2812_tx_driver
    import ws2812_tx_driver_pkg::*;
#(
    parameter int unsigned T0H_CYC  = T0H_CYC_DEF,
    parameter int unsigned T1H_CYC  = T1H_CYC_DEF,
    parameter int unsigned TBIT_CYC = TBIT_CYC_DEF,
    parameter int unsigned TRET_CYC = TRET_CYC_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [WORD_W-1:0] i_data,
    input  logic              i_valid,
    input  logic              i_last,
    output logic              o_ready,
    output logic              o_serial,
    output logic              o_busy,
    output logic              o_underrun
);

    localparam int unsigned CNT_W = $clog2(TRET_CYC + 1);

    tx_state_e         state_q, state_d;
    logic [WORD_W-1:0] shift_q;
    logic [IDX_W-1:0]  idx_q;
    logic              last_q;

    pixel_t            in_word_c, load_word_c, hold_word_c;
    logic              xfer_c, hold_full_c;
    logic              start_c, hold_c, load_c, load_sel_c, shift_c, bit_c;
    logic              underrun_d, ready_d;
    logic [CNT_W-1:0]  cnt;
    logic              high_done_c, bit_done_c;

    assign in_word_c   = '{last: i_last, data: i_data};
    assign xfer_c      = i_valid && o_ready;
    assign load_word_c = load_sel_c ? hold_word_c : in_word_c;
    assign bit_c       = load_c ? load_word_c.data[WORD_W-1] : shift_q[WORD_W-2];

`ifdef WS2812_TX_PREFETCH_EN
    pixel_t hold_q;
    logic   hold_valid_q, hold_valid_d, hold_fill_c, hold_take_c;

    // A transfer not consumed directly by the shifter parks in the holder.
    assign hold_fill_c  = xfer_c && !load_c;
    assign hold_take_c  = load_c && load_sel_c;
    assign hold_valid_d = hold_fill_c || (hold_valid_q && !hold_take_c);
    assign hold_full_c  = hold_valid_q;
    assign hold_word_c  = hold_q;
    assign ready_d      = !hold_valid_d && (state_d != ST_RET);

    // Holding register for the next pixel.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hold_valid_q <= 1'b0;
            hold_q       <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            if (hold_fill_c) begin
                hold_q <= in_word_c;
            end
        end
    end
`else
    assign hold_full_c = 1'b0;
    assign hold_word_c = '0;
    assign ready_d     = (state_d == ST_IDLE) || (state_d == ST_GAP);
`endif

    // State register; reset lands in RET so the chain latches before first use.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_RET;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath controls.
    always_comb begin
        state_d    = state_q;
        start_c    = 1'b0;
        hold_c     = 1'b0;
        load_c     = 1'b0;
        load_sel_c = 1'b0;
        shift_c    = 1'b0;
        underrun_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (hold_full_c) begin
                    load_c     = 1'b1;
                    load_sel_c = 1'b1;
                    start_c    = 1'b1;
                    state_d    = ST_HIGH;
                end else if (xfer_c) begin
                    load_c  = 1'b1;
                    start_c = 1'b1;
                    state_d = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (high_done_c) begin
                    state_d = ST_LOW;
                end
            end
            ST_LOW: begin
                if (bit_done_c) begin
                    if (idx_q != '0) begin
                        shift_c = 1'b1;
                        start_c = 1'b1;
                        state_d = ST_HIGH;
                    end else if (last_q) begin
                        hold_c  = 1'b1;
                        state_d = ST_RET;
                    end else if (hold_full_c) begin
                        load_c     = 1'b1;
                        load_sel_c = 1'b1;
                        start_c    = 1'b1;
                        state_d    = ST_HIGH;
                    end else if (xfer_c) begin
                        load_c  = 1'b1;
                        start_c = 1'b1;
                        state_d = ST_HIGH;
                    end else begin
                        hold_c     = 1'b1;
                        underrun_d = 1'b1;
                        state_d    = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (xfer_c) begin
                    load_c  = 1'b1;
                    start_c = 1'b1;
                    state_d = ST_HIGH;
                end else if (cnt == CNT_W'(TRET_CYC - 1)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RET: begin
                if (cnt == CNT_W'(TRET_CYC - 1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                hold_c  = 1'b1;
                state_d = ST_RET;
            end
        endcase
    end

    // Shift register, bit index and end-of-frame flag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            shift_q <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
        end else if (load_c) begin
            shift_q <= load_word_c.data;
            idx_q   <= IDX_W'(WORD_W - 1);
            last_q  <= load_word_c.last;
        end else if (shift_c) begin
            shift_q <= {shift_q[WORD_W-2:0], 1'b0};
            idx_q   <= idx_q - IDX_W'(1);
        end
    end

    // Registered handshake and status outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_ready    <= 1'b0;
            o_busy     <= 1'b1;
            o_underrun <= 1'b0;
        end else begin
            o_ready    <= ready_d;
            o_busy     <= (state_d != ST_IDLE);
            o_underrun <= underrun_d;
        end
    end

    ws2812_tx_driver_bit_encoder #(
        .T0H_CYC  (T0H_CYC),
        .T1H_CYC  (T1H_CYC),
        .TBIT_CYC (TBIT_CYC),
        .TRET_CYC (TRET_CYC)
    ) u_enc (
        .clk         (i_clk),
        .rst_n       (i_rst_n),
        .start       (start_c),
        .bit_val     (bit_c),
        .hold        (hold_c),
        .serial      (o_serial),
        .cnt         (cnt),
        .high_done_c (high_done_c),
        .bit_done_c  (bit_done_c)
    );

endmodule

// File: tb/tb_ws2812_tx_driver.sv
// Bench for ws2812_tx_driver: directed frames decoded by a two-led chain model.
module tb_ws2812_tx_driver;

    localparam int T0H       = 20;
    localparam int T1H       = 40;
    localparam int TBIT      = 63;
    localparam int TRET      = 2600;
    localparam int LATCH_CYC = 1000;
    localparam int WAIT_MAX  = 30000;

    logic        i_clk   = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [23:0] i_data  = '0;
    logic        i_valid = 1'b0;
    logic        i_last  = 1'b0;
    logic        o_ready, o_serial, o_busy, o_underrun;

    ws2812_tx_driver #(
        .T0H_CYC  (T0H),
        .T1H_CYC  (T1H),
        .TBIT_CYC (TBIT),
        .TRET_CYC (TRET)
    ) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_data     (i_data),
        .i_valid    (i_valid),
        .i_last     (i_last),
        .o_ready    (o_ready),
        .o_serial   (o_serial),
        .o_busy     (o_busy),
        .o_underrun (o_underrun)
    );

    always #10 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Downstream chain model: pulse widths, bit periods, decoded pixels.
    logic        prev_ser   = 1'b0;
    int          hi_run     = 0;
    int          lo_run     = 0;
    int          since_rise = 0;
    bit          in_frame   = 1'b0;
    logic [47:0] rx_bits    = '0;
    int          rx_n       = 0;
    logic [23:0] led0       = '0;
    logic [23:0] led1       = '0;
    int          latches    = 0;
    int          rises      = 0;
    int          underruns  = 0;
    int          hi_q[$];
    int          per_q[$];

    always @(negedge i_clk) begin
        if (o_underrun) underruns++;
        if (o_serial) begin
            if (!prev_ser) begin
                if (in_frame) per_q.push_back(since_rise);
                in_frame   = 1'b1;
                since_rise = 0;
                hi_run     = 0;
                rises++;
            end
            hi_run++;
            lo_run = 0;
        end else begin
            if (prev_ser) begin
                hi_q.push_back(hi_run);
                if (rx_n < 48) rx_bits = {rx_bits[46:0], (hi_run > (T0H + T1H) / 2)};
                rx_n++;
            end
            lo_run++;
            if (lo_run == LATCH_CYC) begin
                if (rx_n >= 48) begin
                    led0 = rx_bits[47:24];
                    led1 = rx_bits[23:0];
                end else if (rx_n >= 24) begin
                    led0 = 24'(rx_bits >> (rx_n - 24));
                end
                if (rx_n > 0) latches++;
                rx_n     = 0;
                rx_bits  = '0;
                in_frame = 1'b0;
            end
        end
        since_rise++;
        prev_ser = o_serial;
    end

    task automatic check_eq(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_word(input logic [23:0] d, input logic l);
        int n = 0;
        @(negedge i_clk);
        i_data  = d;
        i_last  = l;
        i_valid = 1'b1;
        while (!o_ready && n < WAIT_MAX) begin
            @(negedge i_clk);
            n++;
        end
        check_eq("send_accept", 48'(n < WAIT_MAX), 48'd1);
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        @(negedge i_clk);
        while (o_busy && n < WAIT_MAX) begin
            @(negedge i_clk);
            n++;
        end
        check_eq(tag, 48'(n < WAIT_MAX), 48'd1);
    endtask

    // Call at the negedge where reset is released.
    task automatic measure_ret(input string tag);
        int n = 0;
        do begin
            @(negedge i_clk);
            n++;
        end while (!o_ready && n < WAIT_MAX);
        check_eq(tag, 48'(n), 48'(TRET));
    endtask

    initial begin
        logic [23:0] w;
        int          u0, l0, m, hi, bad;

        // Reset values and power-up latch period
        repeat (3) @(negedge i_clk);
        check_eq("rst_serial", 48'(o_serial), 48'd0);
        check_eq("rst_ready", 48'(o_ready), 48'd0);
        check_eq("rst_busy", 48'(o_busy), 48'd1);
        check_eq("rst_underrun", 48'(o_underrun), 48'd0);
        i_rst_n = 1'b1;
        measure_ret("ret_after_reset");
        check_eq("idle_busy", 48'(o_busy), 48'd0);

        // 1: single pixel frame
        l0 = latches;
        send_word(24'hFF00FF, 1'b1);
        check_eq("first_rise", 48'(o_serial), 48'd1);
        wait_idle("t1_idle");
        check_eq("t1_led0", 48'(led0), 48'hFF00FF);
        check_eq("t1_latches", 48'(latches - l0), 48'd1);
        check_eq("t1_serial_idle", 48'(o_serial), 48'd0);

        // 2: pulse widths and periods
        hi_q.delete();
        per_q.delete();
        w = 24'hA5A5A5;
        send_word(w, 1'b1);
        wait_idle("t2_idle");
        check_eq("t2_n_high", 48'(hi_q.size()), 48'd24);
        check_eq("t2_n_period", 48'(per_q.size()), 48'd23);
        for (int i = 0; i < 24 && i < hi_q.size(); i++)
            check_eq($sformatf("t2_high_%0d", i), 48'(hi_q[i]), 48'(w[23-i] ? T1H : T0H));
        for (int i = 0; i < per_q.size(); i++)
            check_eq($sformatf("t2_period_%0d", i), 48'(per_q[i]), 48'(TBIT));

        // 3: two-pixel frame into two leds
        u0 = underruns;
        send_word(24'h123456, 1'b0);
        send_word(24'hABCDEF, 1'b1);
        wait_idle("t3_idle");
        check_eq("t3_led0", 48'(led0), 48'h123456);
        check_eq("t3_led1", 48'(led1), 48'hABCDEF);
`ifdef WS2812_TX_PREFETCH_EN
        check_eq("t3_underruns", 48'(underruns - u0), 48'd0);
`else
        check_eq("t3_underruns", 48'(underruns - u0), 48'd1);
`endif

        // 4: missing second word, GAP timeout latches the frame
        u0 = underruns;
        l0 = latches;
        send_word(24'h00FF00, 1'b0);
        m = 0;
        while (!o_underrun && m < WAIT_MAX) begin
            @(negedge i_clk);
            m++;
        end
        check_eq("t4_underrun_seen", 48'(m < WAIT_MAX), 48'd1);
        check_eq("t4_gap_ready", 48'(o_ready), 48'd1);
        m  = 0;
        hi = 0;
        while (o_busy && m < WAIT_MAX) begin
            @(negedge i_clk);
            m++;
            if (o_serial) hi++;
        end
        check_eq("t4_gap_len", 48'(m), 48'(TRET));
        check_eq("t4_gap_low", 48'(hi), 48'd0);
        check_eq("t4_underruns", 48'(underruns - u0), 48'd1);
        check_eq("t4_led0", 48'(led0), 48'h00FF00);
        check_eq("t4_latches", 48'(latches - l0), 48'd1);

        // 5: reset during the high phase of bit 12
        rises = 0;
        send_word(24'hC3C3C3, 1'b1);
        m = 0;
        while (rises < 12 && m < WAIT_MAX) begin
            @(negedge i_clk);
            m++;
        end
        check_eq("t5_reach_bit12", 48'(m < WAIT_MAX), 48'd1);
        repeat (5) @(negedge i_clk);
        check_eq("t5_high_before", 48'(o_serial), 48'd1);
        #3;
        i_rst_n = 1'b0;
        #1;
        check_eq("t5_serial_async", 48'(o_serial), 48'd0);
        check_eq("t5_ready_rst", 48'(o_ready), 48'd0);
        check_eq("t5_busy_rst", 48'(o_busy), 48'd1);
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        measure_ret("t5_ret_after_reset");

`ifdef WS2812_TX_PREFETCH_EN
        // 6: eight pixels streamed back-to-back
        hi_q.delete();
        per_q.delete();
        u0 = underruns;
        for (int i = 0; i < 8; i++)
            send_word(24'h100000 * (i + 1) + 24'h000A5A, i == 7);
        wait_idle("t6_idle");
        check_eq("t6_n_period", 48'(per_q.size()), 48'd191);
        bad = 0;
        foreach (per_q[i]) if (per_q[i] != TBIT) bad++;
        check_eq("t6_bad_periods", 48'(bad), 48'd0);
        check_eq("t6_underruns", 48'(underruns - u0), 48'd0);
        check_eq("t6_led0", 48'(led0), 48'h100A5A);
        check_eq("t6_led1", 48'(led1), 48'h200A5A);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule
